// File: rtl/timer_bank.sv
// timer_bank: NUM_CH identical up-counting timer channels behind one word-addressed
// register window. Each channel has enable, one-shot, a power-of-two prescaler,
// a terminal value and a sticky flag. The global block at the top of the window
// holds the W1C status flags and the per-channel interrupt enables.
module timer_bank #(
    parameter int          NUM_CH    = 4,
    parameter int          CNT_W     = 16,
    parameter logic [13:0] BASE_ADDR = 14'h0010
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [13:0]       i_memAddr,
    input  logic [15:0]       i_memDataIn,
    input  logic              i_memWrEn,
    output logic [15:0]       o_memDataOut,
    output logic              o_hit,
    input  logic              i_smIsBooted,
    input  logic              i_smIsPaused,
    output logic [NUM_CH-1:0] o_intTMR,
    output logic              o_intAny
);
    localparam int                WIN_WORDS = 4 * (NUM_CH + 1);
    localparam logic [13:0]       END_ADDR  = BASE_ADDR + 14'(WIN_WORDS);
    localparam logic [CNT_W-1:0]  CNT_ONE   = 1;

    // Address decode: block index selects a channel (or the global block), low bits the register.
    logic [13:0] w_off;
    logic [11:0] w_blk;
    logic [1:0]  w_reg;
    logic        w_wr;
    logic        w_glb;

    assign o_hit = (i_memAddr >= BASE_ADDR) && (i_memAddr < END_ADDR);
    assign w_off = i_memAddr - BASE_ADDR;
    assign w_blk = w_off[13:2];
    assign w_reg = w_off[1:0];
    assign w_wr  = i_memWrEn && o_hit;
    assign w_glb = (w_blk == 12'(NUM_CH));

    logic [15:0]       w_ctrl_rd  [NUM_CH];
    logic [15:0]       w_count_rd [NUM_CH];
    logic [15:0]       w_max_rd   [NUM_CH];
    logic [NUM_CH-1:0] w_flag_set;

    logic [NUM_CH-1:0] r_status;
    logic [NUM_CH-1:0] r_irqen;

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            logic             r_en;
            logic             r_oneshot;
            logic [3:0]       r_ps;
            logic [14:0]      r_pre;
            logic [CNT_W-1:0] r_count;
            logic [CNT_W-1:0] r_max;

            logic        w_sel;
            logic        w_wr_ctrl;
            logic        w_wr_count;
            logic        w_wr_max;
            logic        w_run;
            logic [14:0] w_pre_top;
            logic        w_tick;
            logic        w_tick_eff;
            logic        w_term;

            assign w_sel      = w_wr && (w_blk == 12'(c));
            assign w_wr_ctrl  = w_sel && (w_reg == 2'd0);
            assign w_wr_count = w_sel && (w_reg == 2'd1);
            assign w_wr_max   = w_sel && (w_reg == 2'd2);

            assign w_run      = r_en && i_smIsBooted && !i_smIsPaused;
            assign w_pre_top  = 15'((16'd1 << r_ps) - 16'd1);
            assign w_tick     = w_run && (r_pre == w_pre_top);
            // A software COUNT write in the same cycle swallows the tick entirely.
            assign w_tick_eff = w_tick && !w_wr_count;
            assign w_term     = w_tick_eff && (r_count == r_max);

            // Control register; a CTRL write overrides a one-shot auto-disable in the same cycle.
            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn) begin
                    r_en      <= 1'b0;
                    r_oneshot <= 1'b0;
                    r_ps      <= 4'd0;
                end else if (w_wr_ctrl) begin
                    r_en      <= i_memDataIn[0];
                    r_oneshot <= i_memDataIn[1];
                    r_ps      <= i_memDataIn[5:2];
                end else if (w_term && r_oneshot) begin
                    r_en      <= 1'b0;
                end
            end

            // Prescaler: counts run cycles, restarts on every CTRL write.
            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn) begin
                    r_pre <= 15'd0;
                end else if (w_wr_ctrl) begin
                    r_pre <= 15'd0;
                end else if (w_run) begin
                    r_pre <= w_tick ? 15'd0 : (r_pre + 15'd1);
                end
            end

            // Counter: software write wins, otherwise advance or wrap to 0 at the terminal value.
            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn) begin
                    r_count <= '0;
                end else if (w_wr_count) begin
                    r_count <= i_memDataIn[CNT_W-1:0];
                end else if (w_tick_eff) begin
                    r_count <= w_term ? '0 : (r_count + CNT_ONE);
                end
            end

            // Terminal value register.
            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn) begin
                    r_max <= '0;
                end else if (w_wr_max) begin
                    r_max <= i_memDataIn[CNT_W-1:0];
                end
            end

            assign w_ctrl_rd[c]  = {10'd0, r_ps, r_oneshot, r_en};
            assign w_count_rd[c] = 16'(r_count);
            assign w_max_rd[c]   = 16'(r_max);
            assign w_flag_set[c] = w_term;
        end
    endgenerate

    // Sticky status with W1C; a hardware set in the same cycle beats the clear.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_status <= '0;
        end else if (w_wr && w_glb && (w_reg == 2'd0)) begin
            r_status <= (r_status & ~i_memDataIn[NUM_CH-1:0]) | w_flag_set;
        end else begin
            r_status <= r_status | w_flag_set;
        end
    end

    // Interrupt enable register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_irqen <= '0;
        end else if (w_wr && w_glb && (w_reg == 2'd1)) begin
            r_irqen <= i_memDataIn[NUM_CH-1:0];
        end
    end

    // Flat read mux; anything unmapped or outside the window reads 0.
    always_comb begin
        o_memDataOut = 16'd0;
        if (o_hit) begin
            if (w_glb) begin
                case (w_reg)
                    2'd0:    o_memDataOut = 16'(r_status);
                    2'd1:    o_memDataOut = 16'(r_irqen);
                    default: o_memDataOut = 16'd0;
                endcase
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (w_blk == 12'(i)) begin
                        case (w_reg)
                            2'd0:    o_memDataOut = w_ctrl_rd[i];
                            2'd1:    o_memDataOut = w_count_rd[i];
                            2'd2:    o_memDataOut = w_max_rd[i];
                            default: o_memDataOut = 16'd0;
                        endcase
                    end
                end
            end
        end
    end

    assign o_intTMR = r_status & r_irqen;
    assign o_intAny = |o_intTMR;
endmodule
